sha256_stream_core: RTL
=======================

# sha256_stream_core

Runtime-configurable SHA-256 hashing engine, next generation of the team's fixed-size hash block. It fetches a message of runtime-specified byte length from the shared testbench/system word memory, applies SHA-256 padding, and compresses each 512-bit block at one round per cycle. It writes the 8-word digest back to memory and presents it on a parallel port. It sits between a host controller (start/done handshake) and the single-port 32-bit word memory.

## Interface
- SIZE_W, 14: width of the `msg_size` byte-count input; maximum message is 2^SIZE_W−1 bytes.
- ADDR_W, 16: width of word addresses.
- clk  in  1  clock; memory is clocked by the same `clk`.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- msg_size  in  SIZE_W  message length in bytes; latched on an accepted start.
- message_addr  in  ADDR_W  word address of message word 0; latched on an accepted start.
- output_addr  in  ADDR_W  word address for digest word 0; latched on an accepted start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last digest write.
- digest  out  256  {H0..H7}; updated after each block; final value is stable from done until the next accepted start.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory word address.
- mem_write_data  out  32  write data.
- mem_read_data  in  32  read data; valid one cycle after its address is presented.

## Operation
- Words are big-endian: byte 0 of the message is bits [31:24] of message word 0.
- Block count: nb = floor(size/64) + 1 if size%64 < 56, otherwise floor(size/64) + 2.
- States: IDLE → LOAD → COMPUTE → UPDATE → (LOAD if blocks remain, else WRITE) → DONE → IDLE.
- **IDLE**
  - start=1 latches the inputs and loads H0..H7 with the SHA-256 IVs (6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19).
  - Clears the block counter and goes to LOAD.
- **LOAD** (17 cycles)
  - Issues reads only for global word indices < ceil(size/4). Addresses are message_addr + index; ADDR_W wrap-around is allowed.
  - Fills a 16-word buffer, with padding substituted per word:
    - Full message words pass through unchanged.
    - The partial word keeps its size%4 MSBytes and puts 0x80 in the next byte.
    - If size%4==0, the word at index size/4 is 0x80000000.
    - In the last block, word 14 = 0 and word 15 = size×8 (32 bits, zero-extended).
    - All other words are 0.
  - Copies H0..H7 into a..h.
- **COMPUTE** (64 cycles)
  - Performs round t = 0..63 with K[t].
  - The schedule uses a rolling 16-word window; W[t] for t ≥ 16 = σ1(W[t−2]) + W[t−7] + σ0(W[t−15]) + W[t−16], mod 2^32.
- **UPDATE** (1 cycle): Hn += working variable (mod 2^32), digest updates, and the block counter increments.
- **WRITE** (8 cycles): mem_we=1, mem_addr = output_addr + n, mem_write_data = Hn for n = 0..7.
- **DONE** (1 cycle): done=1, busy=0; returns to IDLE.
- All arithmetic is unsigned 32-bit with wrap; rotates are true rotates.
- start while busy is ignored; inputs are not re-sampled during an operation.

## Timing
- Reset values:
  - state=IDLE, busy=0, done=0, mem_we=0, mem_addr=0, mem_write_data=0, digest=0.
  - Reset takes effect immediately, including mid-operation; any write in progress is abandoned.
- Latency: with edge 0 sampling start, done is high in cycle 82·nb + 9.
- Per block: 17 + 64 + 1 = 82 cycles.
- mem_we is high for exactly 8 consecutive cycles per operation and never during LOAD.
- start in the DONE cycle is ignored. start in the first IDLE cycle after DONE is accepted, giving back-to-back operation with one idle cycle.
- size=0 produces one pure-padding block with no memory reads.

## Configuration
- SHA224_MODE_EN defined:
  - Adds input port `mode224` (1 bit), latched at start.
  - When `mode224`=1, the engine uses the SHA-224 IVs (c1059ed8, 367cd507, 3070dd17, f70e5939, ffc00b31, 68581511, 64f98fa7, befa4fa4).
  - WRITE lasts 7 cycles (H0..H6) and done arrives one cycle earlier.
  - digest[31:0] reads as 0 in that mode.
- SHA224_MODE_EN undefined: no `mode224` port; SHA-256 only.

## Test plan
- size=3, word0=0x61626300 ("abc") → digest/memory = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; done at cycle 91.
- size=0 → e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855; no mem reads issued.
- Padding boundaries:
  - size=55 → 1 block, done at cycle 91.
  - size=56 → 2 blocks, done at cycle 173.
  - size=64 → 2 blocks.
  - Digests must match the software model.
- start pulsed again at cycle 40 of an operation, then reset_n low at cycle 120 of a 2-block run:
  - The second start is ignored.
  - After reset, busy=0, mem_we=0 and state=IDLE asynchronously.
  - A fresh start gives the correct digest.
- With SHA224_MODE_EN defined, mode224=1, "abc" → 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7; exactly 7 writes, done at cycle 90.

Source files
------------

// File: rtl/sha256_stream_core.sv
// sha256_stream_core: fetches a message from word memory, pads it, hashes it at one
// SHA-256 round per clock and writes the digest back. Define SHA224_MODE_EN for SHA-224.
module sha256_stream_core #(
   parameter int SIZE_W = 14,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [SIZE_W-1:0] msg_size,
   input  logic [ADDR_W-1:0] message_addr,
   input  logic [ADDR_W-1:0] output_addr,
`ifdef SHA224_MODE_EN
   input  logic              mode224,
`endif
   output logic              busy,
   output logic              done,
   output logic [255:0]      digest,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_write_data,
   input  logic [31:0]       mem_read_data
);

   localparam int BLK_W = SIZE_W - 5;
   localparam int IDX_W = BLK_W + 4;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_COMPUTE, S_UPDATE, S_WRITE, S_DONE
   } state_t;

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [31:0] IV256 [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };
`ifdef SHA224_MODE_EN
   localparam logic [31:0] IV224 [8] = '{
      32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
      32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
   };
`endif

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] bsig0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] bsig1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   state_t              state_q, state_d;
   logic [6:0]          cnt_q, cnt_d;
   logic [BLK_W-1:0]    blk_q, blk_d;
   logic [BLK_W-1:0]    nb_q, nb_d;
   logic [SIZE_W-1:0]   size_q, size_d;
   logic [ADDR_W-1:0]   maddr_q, maddr_d;
   logic [ADDR_W-1:0]   oaddr_q, oaddr_d;
   logic [31:0]         h_q [8];
   logic [31:0]         h_d [8];
   logic [31:0]         v_q [8];
   logic [31:0]         v_d [8];
   logic [31:0]         w_q [16];
   logic [31:0]         w_d [16];
   logic [255:0]        dig_q, dig_d;
`ifdef SHA224_MODE_EN
   logic                mode_q, mode_d;
`endif

   logic [SIZE_W-3:0]   full_w;
   logic [1:0]          rem;
   logic [IDX_W-1:0]    g_iss, g_cap;
   logic [3:0]          idx_cap;
   logic                rd_en, last_blk;
   logic [31:0]         pad_w, t1, t2, w_new;
   logic [BLK_W-1:0]    nb_calc;
   logic [2:0]          last_wr;

   assign full_w = size_q[SIZE_W-1:2];
   assign rem    = size_q[1:0];

   // Block count from the raw input so it can be latched together with the size.
   assign nb_calc = BLK_W'(msg_size[SIZE_W-1:6]) +
                    ((msg_size[5:0] < 6'd56) ? BLK_W'(1) : BLK_W'(2));

   always_comb begin
      g_iss    = {blk_q, cnt_q[3:0]};
      idx_cap  = cnt_q[3:0] - 4'd1;
      g_cap    = {blk_q, idx_cap};
      rd_en    = (g_iss < IDX_W'(full_w)) || ((g_iss == IDX_W'(full_w)) && (rem != 2'd0));
      last_blk = (blk_q == nb_q - BLK_W'(1));

      pad_w = 32'h0;
      if (last_blk && idx_cap == 4'd14) begin
         pad_w = 32'h0;
      end else if (last_blk && idx_cap == 4'd15) begin
         pad_w = 32'({size_q, 3'b000});
      end else if (g_cap < IDX_W'(full_w)) begin
         pad_w = mem_read_data;
      end else if (g_cap == IDX_W'(full_w)) begin
         unique case (rem)
            2'd0: pad_w = 32'h8000_0000;
            2'd1: pad_w = {mem_read_data[31:24], 8'h80, 16'h0};
            2'd2: pad_w = {mem_read_data[31:16], 8'h80, 8'h0};
            2'd3: pad_w = {mem_read_data[31:8], 8'h80};
         endcase
      end

      t1 = v_q[7] + bsig1(v_q[4]) + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6])) +
           K[cnt_q[5:0]] + w_q[0];
      t2 = bsig0(v_q[0]) + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
      w_new = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];
   end

`ifdef SHA224_MODE_EN
   assign last_wr = mode_q ? 3'd6 : 3'd7;
   assign digest  = mode_q ? {dig_q[255:32], 32'h0} : dig_q;
`else
   assign last_wr = 3'd7;
   assign digest  = dig_q;
`endif

   always_comb begin
      // NOTE: every _d starts from its _q and every output gets a default, so no
      // path through this block leaves a signal unassigned and no latch is inferred.
      state_d        = state_q;
      cnt_d          = cnt_q;
      blk_d          = blk_q;
      nb_d           = nb_q;
      size_d         = size_q;
      maddr_d        = maddr_q;
      oaddr_d        = oaddr_q;
      h_d            = h_q;
      v_d            = v_q;
      w_d            = w_q;
      dig_d          = dig_q;
`ifdef SHA224_MODE_EN
      mode_d         = mode_q;
`endif
      busy           = 1'b1;
      done           = 1'b0;
      mem_we         = 1'b0;
      mem_addr       = '0;
      mem_write_data = 32'h0;

      unique case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               size_d  = msg_size;
               maddr_d = message_addr;
               oaddr_d = output_addr;
               nb_d    = nb_calc;
               blk_d   = '0;
               cnt_d   = '0;
`ifdef SHA224_MODE_EN
               mode_d  = mode224;
               for (int i = 0; i < 8; i++) h_d[i] = mode224 ? IV224[i] : IV256[i];
`else
               for (int i = 0; i < 8; i++) h_d[i] = IV256[i];
`endif
               state_d = S_LOAD;
            end
         end

         // Address for word cnt goes out in cycle cnt; its data is captured in cnt+1.
         S_LOAD: begin
            if (cnt_q < 7'd16 && rd_en) mem_addr = maddr_q + ADDR_W'(g_iss);
            if (cnt_q != 7'd0) w_d[idx_cap] = pad_w;
            if (cnt_q == 7'd16) begin
               v_d     = h_q;
               cnt_d   = '0;
               state_d = S_COMPUTE;
            end else begin
               cnt_d = cnt_q + 7'd1;
            end
         end

         S_COMPUTE: begin
            v_d[0] = t1 + t2;
            v_d[1] = v_q[0];
            v_d[2] = v_q[1];
            v_d[3] = v_q[2];
            v_d[4] = v_q[3] + t1;
            v_d[5] = v_q[4];
            v_d[6] = v_q[5];
            v_d[7] = v_q[6];
            for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
            w_d[15] = w_new;
            if (cnt_q == 7'd63) begin
               cnt_d   = '0;
               state_d = S_UPDATE;
            end else begin
               cnt_d = cnt_q + 7'd1;
            end
         end

         S_UPDATE: begin
            for (int i = 0; i < 8; i++) begin
               h_d[i] = h_q[i] + v_q[i];
               dig_d[255-32*i -: 32] = h_d[i];
            end
            blk_d   = blk_q + BLK_W'(1);
            cnt_d   = '0;
            state_d = last_blk ? S_WRITE : S_LOAD;
         end

         S_WRITE: begin
            mem_we         = 1'b1;
            mem_addr       = oaddr_q + ADDR_W'(cnt_q[2:0]);
            mem_write_data = h_q[cnt_q[2:0]];
            if (cnt_q[2:0] == last_wr) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 7'd1;
            end
         end

         S_DONE: begin
            busy    = 1'b0;
            done    = 1'b1;
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         blk_q   <= '0;
         nb_q    <= '0;
         size_q  <= '0;
         maddr_q <= '0;
         oaddr_q <= '0;
         dig_q   <= '0;
`ifdef SHA224_MODE_EN
         mode_q  <= 1'b0;
`endif
         for (int i = 0; i < 8; i++) h_q[i] <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         blk_q   <= blk_d;
         nb_q    <= nb_d;
         size_q  <= size_d;
         maddr_q <= maddr_d;
         oaddr_q <= oaddr_d;
         dig_q   <= dig_d;
`ifdef SHA224_MODE_EN
         mode_q  <= mode_d;
`endif
         h_q     <= h_d;
      end
   end

   // NOTE: message buffer and working variables have no reset; LOAD fully
   // rewrites both before COMPUTE ever reads them.
   always_ff @(posedge clk) begin
      w_q <= w_d;
      v_q <= v_d;
   end

endmodule
